// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file.
// Holds the clear-sequencer state encoding.
package rf_pkg;

  localparam logic RF_IDLE  = 1'b0;
  localparam logic RF_CLEAR = 1'b1;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: sweeps every entry to zero after a clr_req pulse.
// Ports: clk, rst (async high), clr_req in; busy, clr_we, clr_addr out.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  logic              state_q;
  logic              state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        // counter wraps to 0 on the same edge that leaves CLEAR
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = RF_IDLE;
        end
      end
      default: begin
        state_d = RF_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// Register file: 1 write port, 2 read ports, optional bypass,
// registered reads, hardwired zero entry and a clear sweep.
// Ports: clk, rst, we/waddr/wdata, raddr1/2 -> rdata1/2,
// clr_req in, busy out.
module reg_file_param
  import rf_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int REG_READ = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_acc;
  logic              wr_zero;
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_d;

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // a clear request in IDLE beats a same-cycle write
  assign wr_zero = (ZERO_REG != 0) && (waddr == '0);
  assign wr_acc  = we && !busy && !clr_req && !wr_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem_q[waddr] <= wdata;
    end
  end

  // zero entry takes priority over the bypass path
  always_comb begin
    rd1_d = mem_q[raddr1];
    if ((ZERO_REG != 0) && (raddr1 == '0)) begin
      rd1_d = '0;
    end else if ((BYPASS != 0) && wr_acc
                 && (waddr == raddr1)) begin
      rd1_d = wdata;
    end
  end

  always_comb begin
    rd2_d = mem_q[raddr2];
    if ((ZERO_REG != 0) && (raddr2 == '0)) begin
      rd2_d = '0;
    end else if ((BYPASS != 0) && wr_acc
                 && (waddr == raddr2)) begin
      rd2_d = wdata;
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg
      logic [DATA_W-1:0] rd1_q;
      logic [DATA_W-1:0] rd2_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd1_q <= '0;
          rd2_q <= '0;
        end else begin
          rd1_q <= rd1_d;
          rd2_q <= rd2_d;
        end
      end

      assign rdata1 = rd1_q;
      assign rdata2 = rd2_q;
    end else begin : g_comb
      assign rdata1 = rd1_d;
      assign rdata2 = rd2_d;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: four configurations share
// one stimulus stream and one reference model.
module tb_reg_file_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [1:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [1:0] raddr1 = '0;
  logic [1:0] raddr2 = '0;
  logic       clr_req = 1'b0;

  logic [7:0] a1, a2, b1, b2, c1, c2, d1, d2;
  logic       abusy, bbusy, cbusy, dbusy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // A: comb, bypass           B: registered, no bypass
  // C: comb, no bypass, zero  D: registered, bypass, zero
  reg_file_param #(.DATA_W(8), .ADDR_W(2), .REG_READ(0),
    .BYPASS(1), .ZERO_REG(0)) u_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(a1), .rdata2(a2), .clr_req(clr_req),
    .busy(abusy));

  reg_file_param #(.DATA_W(8), .ADDR_W(2), .REG_READ(1),
    .BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(b1), .rdata2(b2), .clr_req(clr_req),
    .busy(bbusy));

  reg_file_param #(.DATA_W(8), .ADDR_W(2), .REG_READ(0),
    .BYPASS(0), .ZERO_REG(1)) u_c (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(c1), .rdata2(c2), .clr_req(clr_req),
    .busy(cbusy));

  reg_file_param #(.DATA_W(8), .ADDR_W(2), .REG_READ(1),
    .BYPASS(1), .ZERO_REG(1)) u_d (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(d1), .rdata2(d2), .clr_req(clr_req),
    .busy(dbusy));

  typedef struct packed {
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] y1;
    logic [7:0] y2;
    logic       bsy;
  } exp_t;

  exp_t cq[$];
  exp_t rq[$];

  // reference model: contents plus remaining sweep cycles
  logic [7:0] m [4];
  int sl = 0;
  int si = 0;

  task automatic chk(string nm, logic [7:0] act,
                     logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mexp(
    logic [1:0] a, bit bp, bit zr, bit w,
    logic [1:0] wa, logic [7:0] wd, bit c);
    bit acc;
    acc = w && (sl == 0) && !c;
    if (zr && a == 2'd0) return 8'h00;
    if (bp && acc && wa == a) return wd;
    return m[a];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (cq.size() > 0) begin
        e = cq.pop_front();
        chk("A.rdata1", a1, e.x1);
        chk("A.rdata2", a2, e.x2);
        chk("C.rdata1", c1, e.y1);
        chk("C.rdata2", c2, e.y2);
        chk("A.busy", {7'd0, abusy}, {7'd0, e.bsy});
        chk("B.busy", {7'd0, bbusy}, {7'd0, e.bsy});
        chk("C.busy", {7'd0, cbusy}, {7'd0, e.bsy});
        chk("D.busy", {7'd0, dbusy}, {7'd0, e.bsy});
      end
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("B.rdata1", b1, e.x1);
        chk("B.rdata2", b2, e.x2);
        chk("D.rdata1", d1, e.y1);
        chk("D.rdata2", d2, e.y2);
      end
    end
  end

  // one cycle of stimulus, entered and left at posedge+1
  task automatic step(bit w, logic [1:0] wa,
                      logic [7:0] wd, logic [1:0] r1,
                      logic [1:0] r2, bit c);
    exp_t ce;
    exp_t re;
    we = w; waddr = wa; wdata = wd;
    raddr1 = r1; raddr2 = r2; clr_req = c;
    ce.x1 = mexp(r1, 1, 0, w, wa, wd, c);
    ce.x2 = mexp(r2, 1, 0, w, wa, wd, c);
    ce.y1 = mexp(r1, 0, 1, w, wa, wd, c);
    ce.y2 = mexp(r2, 0, 1, w, wa, wd, c);
    ce.bsy = (sl > 0);
    re.x1 = mexp(r1, 0, 0, w, wa, wd, c);
    re.x2 = mexp(r2, 0, 0, w, wa, wd, c);
    re.y1 = mexp(r1, 1, 1, w, wa, wd, c);
    re.y2 = mexp(r2, 1, 1, w, wa, wd, c);
    re.bsy = 1'b0;
    cq.push_back(ce);
    rq.push_back(re);
    if (sl > 0) begin
      m[si] = 8'h00;
      si++;
      sl--;
    end else if (c) begin
      sl = 4;
      si = 0;
    end else if (w) begin
      m[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  // asynchronous reset raised mid-cycle, checked at once
  task automatic do_reset();
    exp_t z;
    we = 1'b0;
    clr_req = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst.A1", a1, 8'h00); chk("rst.A2", a2, 8'h00);
    chk("rst.B1", b1, 8'h00); chk("rst.B2", b2, 8'h00);
    chk("rst.C1", c1, 8'h00); chk("rst.C2", c2, 8'h00);
    chk("rst.D1", d1, 8'h00); chk("rst.D2", d2, 8'h00);
    chk("rst.busyA", {7'd0, abusy}, 8'h00);
    chk("rst.busyD", {7'd0, dbusy}, 8'h00);
    cq.delete();
    rq.delete();
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    sl = 0;
    si = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    z = '0;
    rq.push_back(z);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // basic write then read
    step(1, 2'd2, 8'hA5, 2'd0, 2'd1, 0);
    step(1, 2'd3, 8'h3C, 2'd2, 2'd2, 0);
    step(0, 2'd0, 8'h00, 2'd2, 2'd3, 0);
    step(0, 2'd0, 8'h00, 2'd2, 2'd3, 0);

    // same-cycle bypass, then old value check
    step(1, 2'd1, 8'h77, 2'd1, 2'd2, 0);
    step(1, 2'd1, 8'h12, 2'd1, 2'd1, 0);
    step(0, 2'd0, 8'h00, 2'd1, 2'd1, 0);

    // write to entry 0 (discarded on zero-reg configs)
    step(1, 2'd0, 8'hFF, 2'd0, 2'd0, 0);
    step(0, 2'd0, 8'h00, 2'd0, 2'd0, 0);

    // clear sweep with writes dropped
    for (int i = 0; i < 4; i++)
      step(1, 2'(i), 8'(8'h11 * (i + 1)), 2'(i), 2'd3, 0);
    step(1, 2'd3, 8'hEE, 2'd3, 2'd2, 1);
    for (int i = 0; i < 4; i++)
      step(1, 2'd3, 8'h99, 2'(i), 2'd3, 1);
    step(0, 2'd0, 8'h00, 2'd3, 2'd2, 0);
    step(0, 2'd0, 8'h00, 2'd1, 2'd0, 0);

    // reset with live contents
    for (int i = 0; i < 4; i++)
      step(1, 2'(i), 8'($urandom_range(1, 255)),
           2'(i), 2'd0, 0);
    do_reset();
    step(0, 2'd0, 8'h00, 2'd0, 2'd1, 0);
    step(0, 2'd0, 8'h00, 2'd2, 2'd3, 0);

    // reset on the second sweep cycle
    for (int i = 0; i < 4; i++)
      step(1, 2'(i), 8'(8'h40 + i), 2'(i), 2'd1, 0);
    step(0, 2'd0, 8'h00, 2'd1, 2'd2, 1);
    step(0, 2'd0, 8'h00, 2'd0, 2'd1, 0);
    do_reset();
    step(1, 2'd2, 8'h5A, 2'd2, 2'd2, 0);
    step(0, 2'd0, 8'h00, 2'd2, 2'd1, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 7,
           2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 39) == 0);
    end

    step(0, 2'd0, 8'h00, 2'd1, 2'd2, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
